// File: rtl/ahb_sram_ws.sv
// AHB-Lite slave in front of a pipelined single-port SRAM with configurable read latency.
// Writes are posted through a one-entry byte-masked buffer; reads to the buffered word are forwarded.
module ahb_sram_ws #(
  parameter int AW     = 12,
  parameter int RD_LAT = 1
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic          HREADY,
  input  logic [31:0]   HWDATA,
  input  logic [2:0]    HSIZE,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  input  logic [31:0]   SRAMRDATA,
  output logic [3:0]    SRAMWEN,
  output logic [31:0]   SRAMWDATA,
  output logic          SRAMCS,
  output logic [AW-3:0] SRAMADDR
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RDWAIT = 2'd1;
  localparam logic [1:0] ST_ERR1   = 2'd2;
  localparam logic [1:0] ST_ERR2   = 2'd3;
  localparam logic [2:0] CNT_INIT  = 3'(RD_LAT - 1);

  if ((RD_LAT < 1) || (RD_LAT > 8)) begin : g_bad_rd_lat
    $error("ahb_sram_ws: RD_LAT must be within 1..8");
  end

  logic [1:0]    r_state;
  logic [2:0]    r_cnt;
  logic [3:0]    r_buf_we;
  logic [AW-3:0] r_buf_addr;
  logic [31:0]   r_buf_data;
  logic          r_pend;
  logic          r_data_en;
  logic          r_hit;

  logic       w_acc;
  logic       w_err;
  logic       w_rd;
  logic       w_wr;
  logic       w_ram_write;
  logic [3:0] w_lanes;
  logic       w_unused;

  assign w_unused = ^HADDR[31:AW];

  assign w_acc = HSEL & HREADY & HTRANS[1];
  assign w_err = (HSIZE > 3'd2)
               | ((HSIZE == 3'd1) & HADDR[0])
               | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
  assign w_rd  = w_acc & ~HWRITE & ~w_err;
  assign w_wr  = w_acc &  HWRITE & ~w_err;

  // A read always owns the SRAM port; the posted write waits for a free cycle.
  assign w_ram_write = (r_pend | r_data_en) & ~w_rd;

  always_comb begin
    w_lanes = 4'b1111;
    case (HSIZE)
      3'd0:    w_lanes = 4'b0001 << HADDR[1:0];
      3'd1:    w_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_lanes = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERR2: begin
          if (w_acc & w_err) begin
            r_state <= ST_ERR1;
          end else if (w_rd && (RD_LAT > 1)) begin
            r_state <= ST_RDWAIT;
            r_cnt   <= CNT_INIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RDWAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) r_state <= ST_IDLE;
        end
        ST_ERR1: r_state <= ST_ERR2;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_buf_we   <= 4'b0000;
      r_buf_addr <= '0;
      r_pend     <= 1'b0;
      r_data_en  <= 1'b0;
      r_hit      <= 1'b0;
    end else begin
      r_data_en <= w_wr;
      r_pend    <= (r_pend | r_data_en) & w_rd;
      if (w_wr) begin
        r_buf_addr <= HADDR[AW-1:2];
        r_buf_we   <= w_lanes;
      end
      if (w_rd) r_hit <= (HADDR[AW-1:2] == r_buf_addr);
    end
  end

  // Buffer contents are only meaningful under r_buf_we, so they carry no reset.
  always_ff @(posedge HCLK) begin
    for (int b = 0; b < 4; b++) begin
      if (r_data_en && r_buf_we[b]) r_buf_data[b*8 +: 8] <= HWDATA[b*8 +: 8];
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
    assign HRDATA[gi*8 +: 8] = (r_hit & r_buf_we[gi]) ? r_buf_data[gi*8 +: 8]
                                                      : SRAMRDATA[gi*8 +: 8];
  end

  assign HREADYOUT = (r_state == ST_IDLE) | (r_state == ST_ERR2);
  assign HRESP     = (r_state == ST_ERR1) | (r_state == ST_ERR2);

  // Back-to-back writes commit the older one straight from HWDATA.
  assign SRAMCS    = w_rd | w_ram_write;
  assign SRAMADDR  = w_rd ? HADDR[AW-1:2] : r_buf_addr;
  assign SRAMWEN   = w_ram_write ? r_buf_we : 4'b0000;
  assign SRAMWDATA = r_pend ? r_buf_data : HWDATA;

endmodule

// File: tb/tb_ahb_sram_ws.sv
// Directed bench: three bridges (RD_LAT 1, 4, 3) share one AHB stimulus bus, each with its own SRAM model.
module tb_ahb_sram_ws;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel [3];
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;

  logic        hready_o [3];
  logic        hresp    [3];
  logic [31:0] hrdata   [3];
  logic [31:0] sramrdata[3];
  logic [3:0]  sramwen  [3];
  logic [31:0] sramwdata[3];
  logic        sramcs   [3];
  logic [9:0]  sramaddr [3];

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int L = (gi == 0) ? 1 : (gi == 1) ? 4 : 3;

    ahb_sram_ws #(.AW(12), .RD_LAT(L)) u_dut (
      .HCLK      (clk),
      .HRESETn   (rst_n),
      .HSEL      (sel[gi]),
      .HADDR     (haddr),
      .HTRANS    (htrans),
      .HWRITE    (hwrite),
      .HREADY    (hready_o[gi]),
      .HWDATA    (hwdata),
      .HSIZE     (hsize),
      .HREADYOUT (hready_o[gi]),
      .HRESP     (hresp[gi]),
      .HRDATA    (hrdata[gi]),
      .SRAMRDATA (sramrdata[gi]),
      .SRAMWEN   (sramwen[gi]),
      .SRAMWDATA (sramwdata[gi]),
      .SRAMCS    (sramcs[gi]),
      .SRAMADDR  (sramaddr[gi])
    );

    logic [31:0] mem  [1024];
    logic [31:0] pipe [L];
    int wr_cnt = 0;

    always @(posedge clk) begin
      pipe[0] <= (sramcs[gi] && sramwen[gi] == 4'b0000) ? mem[sramaddr[gi]] : 32'hBAD0BAD0;
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
      if (sramcs[gi] && sramwen[gi] != 4'b0000) begin
        wr_cnt <= wr_cnt + 1;
        for (int b = 0; b < 4; b++)
          if (sramwen[gi][b]) mem[sramaddr[gi]][b*8 +: 8] <= sramwdata[gi][b*8 +: 8];
      end
    end
    assign sramrdata[gi] = pipe[L-1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic bus_idle;
    for (int i = 0; i < 3; i++) sel[i] = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd2;
    haddr  = 32'h0;
  endtask

  task automatic bus_req(input int i, input logic [31:0] a, input logic w, input logic [2:0] sz);
    bus_idle();
    sel[i] = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
  endtask

  initial begin
    rst_n  = 1'b0;
    hwdata = 32'h0;
    bus_idle();
    tick();
    settle();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_hready%0d", i), 32'(hready_o[i]), 32'd1);
      chk($sformatf("rst_hresp%0d", i), 32'(hresp[i]), 32'd0);
      chk($sformatf("rst_cs%0d", i), 32'(sramcs[i]), 32'd0);
    end
    tick();
    rst_n = 1'b1;
    tick();

    // Word write then later read, zero wait states (RD_LAT=1)
    bus_req(0, 32'h010, 1'b1, 3'd2); settle();
    chk("t1_addr_cs", 32'(sramcs[0]), 32'd0);
    tick();
    bus_idle(); hwdata = 32'hDEADBEEF; settle();
    chk("t1_drain_cs", 32'(sramcs[0]), 32'd1);
    chk("t1_drain_wen", 32'(sramwen[0]), 32'hF);
    chk("t1_drain_addr", 32'(sramaddr[0]), 32'h004);
    chk("t1_drain_wdata", sramwdata[0], 32'hDEADBEEF);
    tick();
    settle();
    chk("t1_idle_cs", 32'(sramcs[0]), 32'd0);
    tick();
    bus_req(0, 32'h010, 1'b0, 3'd2); settle();
    chk("t1_rd_cs", 32'(sramcs[0]), 32'd1);
    chk("t1_rd_wen", 32'(sramwen[0]), 32'h0);
    chk("t1_rd_addr", 32'(sramaddr[0]), 32'h004);
    tick();
    bus_idle(); settle();
    chk("t1_rd_ready", 32'(hready_o[0]), 32'd1);
    chk("t1_rd_data", hrdata[0], 32'hDEADBEEF);
    tick();

    // Write immediately followed by read of same word: read first, data forwarded
    bus_req(0, 32'h020, 1'b1, 3'd2); settle();
    tick();
    bus_req(0, 32'h020, 1'b0, 3'd2); hwdata = 32'h11223344; settle();
    chk("t2_rd_cs", 32'(sramcs[0]), 32'd1);
    chk("t2_rd_wen", 32'(sramwen[0]), 32'h0);
    chk("t2_rd_addr", 32'(sramaddr[0]), 32'h008);
    tick();
    bus_idle(); hwdata = 32'h0; settle();
    chk("t2_fwd_ready", 32'(hready_o[0]), 32'd1);
    chk("t2_fwd_data", hrdata[0], 32'h11223344);
    chk("t2_drain_wen", 32'(sramwen[0]), 32'hF);
    chk("t2_drain_addr", 32'(sramaddr[0]), 32'h008);
    chk("t2_drain_wdata", sramwdata[0], 32'h11223344);
    tick();
    settle();
    chk("t2_after_cs", 32'(sramcs[0]), 32'd0);
    tick();

    // RD_LAT=4: preload 0x040, post a write to 0x044, then read 0x040
    bus_req(1, 32'h040, 1'b1, 3'd2); settle();
    tick();
    bus_req(1, 32'h044, 1'b1, 3'd2); hwdata = 32'hCAFEF00D; settle();
    chk("t3_b2b_wen", 32'(sramwen[1]), 32'hF);
    chk("t3_b2b_addr", 32'(sramaddr[1]), 32'h010);
    chk("t3_b2b_wdata", sramwdata[1], 32'hCAFEF00D);
    tick();
    bus_req(1, 32'h040, 1'b0, 3'd2); hwdata = 32'h55667788; settle();
    chk("t3_rd_wen", 32'(sramwen[1]), 32'h0);
    chk("t3_rd_addr", 32'(sramaddr[1]), 32'h010);
    tick();
    bus_idle(); hwdata = 32'h0; settle();
    chk("t3_w1_ready", 32'(hready_o[1]), 32'd0);
    chk("t3_w1_wen", 32'(sramwen[1]), 32'hF);
    chk("t3_w1_addr", 32'(sramaddr[1]), 32'h011);
    chk("t3_w1_wdata", sramwdata[1], 32'h55667788);
    tick();
    settle();
    chk("t3_w2_ready", 32'(hready_o[1]), 32'd0);
    chk("t3_w2_cs", 32'(sramcs[1]), 32'd0);
    tick();
    settle();
    chk("t3_w3_ready", 32'(hready_o[1]), 32'd0);
    tick();
    settle();
    chk("t3_done_ready", 32'(hready_o[1]), 32'd1);
    chk("t3_done_resp", 32'(hresp[1]), 32'd0);
    chk("t3_done_data", hrdata[1], 32'hCAFEF00D);
    tick();

    // Misaligned halfword write, then oversized read issued in ERR2
    bus_req(0, 32'h003, 1'b1, 3'd1); settle();
    chk("t4_a_cs", 32'(sramcs[0]), 32'd0);
    tick();
    bus_idle(); settle();
    chk("t4_e1_ready", 32'(hready_o[0]), 32'd0);
    chk("t4_e1_resp", 32'(hresp[0]), 32'd1);
    chk("t4_e1_cs", 32'(sramcs[0]), 32'd0);
    tick();
    bus_req(0, 32'h000, 1'b0, 3'd3); settle();
    chk("t4_e2_ready", 32'(hready_o[0]), 32'd1);
    chk("t4_e2_resp", 32'(hresp[0]), 32'd1);
    chk("t4_b_cs", 32'(sramcs[0]), 32'd0);
    tick();
    bus_idle(); settle();
    chk("t4_e1b_ready", 32'(hready_o[0]), 32'd0);
    chk("t4_e1b_resp", 32'(hresp[0]), 32'd1);
    chk("t4_e1b_cs", 32'(sramcs[0]), 32'd0);
    tick();
    settle();
    chk("t4_e2b_ready", 32'(hready_o[0]), 32'd1);
    chk("t4_e2b_resp", 32'(hresp[0]), 32'd1);
    tick();
    settle();
    chk("t4_idle_resp", 32'(hresp[0]), 32'd0);
    tick();

    // Byte write over a zeroed word, forwarded read, then read from SRAM after drain
    bus_req(0, 32'h104, 1'b1, 3'd2); settle();
    tick();
    bus_req(0, 32'h105, 1'b1, 3'd0); hwdata = 32'h00000000; settle();
    chk("t5_zero_wen", 32'(sramwen[0]), 32'hF);
    chk("t5_zero_addr", 32'(sramaddr[0]), 32'h041);
    tick();
    bus_req(0, 32'h104, 1'b0, 3'd2); hwdata = 32'h5A5AAB5A; settle();
    chk("t5_rd_wen", 32'(sramwen[0]), 32'h0);
    tick();
    bus_idle(); hwdata = 32'h0; settle();
    chk("t5_fwd_data", hrdata[0], 32'h0000AB00);
    chk("t5_drain_wen", 32'(sramwen[0]), 32'h2);
    chk("t5_drain_addr", 32'(sramaddr[0]), 32'h041);
    chk("t5_drain_byte", 32'(sramwdata[0][15:8]), 32'hAB);
    tick();
    bus_req(0, 32'h200, 1'b1, 3'd2); settle();
    tick();
    bus_idle(); hwdata = 32'h77777777; settle();
    chk("t5_other_addr", 32'(sramaddr[0]), 32'h080);
    tick();
    bus_req(0, 32'h104, 1'b0, 3'd2); hwdata = 32'h0; settle();
    tick();
    bus_idle(); settle();
    chk("t5_sram_data", hrdata[0], 32'h0000AB00);
    tick();

    // RD_LAT=3: reset during RDWAIT while a write is pending
    bus_req(2, 32'h080, 1'b1, 3'd2); settle();
    tick();
    bus_req(2, 32'h084, 1'b0, 3'd2); hwdata = 32'h99999999; settle();
    chk("t6_rd_cs", 32'(sramcs[2]), 32'd1);
    chk("t6_rd_wen", 32'(sramwen[2]), 32'h0);
    tick();
    bus_idle(); hwdata = 32'h0;
    rst_n = 1'b0; settle();
    chk("t6_rst_ready", 32'(hready_o[2]), 32'd1);
    chk("t6_rst_resp", 32'(hresp[2]), 32'd0);
    chk("t6_rst_cs", 32'(sramcs[2]), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      settle();
      chk($sformatf("t6_post_cs%0d", c), 32'(sramcs[2]), 32'd0);
    end
    chk("t6_wr_cnt", 32'(g_inst[2].wr_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
